// File: rtl/c_stage.sv
// C (memory-access) stage: req/ack data-memory loads and stores,
// load lane extraction and the registered writeback bundle for W.
module c_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  output logic             c_ready,
  input  logic [XLEN-1:0]  a_pc,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  input  logic [REG_W-1:0] regD,
  input  logic             w_en,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [2:0]       mem_size,
  output logic             dm_req,
  output logic             dm_we,
  output logic [XLEN-1:0]  dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  output logic [3:0]       dm_be,
  input  logic             dm_ack,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             c_valid,
  input  logic             w_ready,
  output logic [XLEN-1:0]  c_pc,
  output logic             w_regfile,
  output logic [REG_W-1:0] sel_regfile,
  output logic [XLEN-1:0]  data_regfile,
  output logic             misalign
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]  p_pc, p_addr, rbuf;
  logic [REG_W-1:0] p_rd;
  logic [2:0]       p_size;
  logic             p_wen, p_ld, done;

  logic             is_mem, bad_sz, bad;
  logic             out_free, accept, ack_hit, finish;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata, rword, ld_val;
  logic [7:0]       lb;
  logic [15:0]      lh;

  assign off    = alu_result[1:0];
  assign is_mem = mem_rd || mem_wr;

  always_comb begin
    bad_sz = 1'b0;
    unique case (mem_size)
      3'd1, 3'd5:       bad_sz = off[0];
      3'd2:             bad_sz = |off;
      3'd3, 3'd6, 3'd7: bad_sz = 1'b1;
      default:          bad_sz = 1'b0;
    endcase
  end

  assign bad = is_mem && bad_sz;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    unique case (mem_size[1:0])
      2'd0: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // an ack that arrived while W was stalled is parked in rbuf
  assign rword = done ? rbuf : dm_rdata;
  assign lb    = rword[{p_addr[1:0], 3'b000} +: 8];
  assign lh    = p_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_val = rword;
    unique case (p_size)
      3'd0:    ld_val = {{24{lb[7]}}, lb};
      3'd1:    ld_val = {{16{lh[15]}}, lh};
      3'd4:    ld_val = {24'd0, lb};
      3'd5:    ld_val = {16'd0, lh};
      default: ;
    endcase
  end

  assign out_free = !c_valid || w_ready;
  assign c_ready  = !reset && (state == IDLE) && out_free;
  assign accept   = a_valid && c_ready;
  assign dm_req   = (state == MEM) && !done;
  assign ack_hit  = dm_req && dm_ack;
  assign finish   = (state == MEM) && out_free && (done || ack_hit);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mem && !bad) state_nxt = MEM;
      MEM:  if (finish) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_pc         <= '0;
      p_addr       <= '0;
      p_rd         <= '0;
      p_size       <= '0;
      p_wen        <= 1'b0;
      p_ld         <= 1'b0;
      done         <= 1'b0;
      rbuf         <= '0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_be        <= '0;
      c_valid      <= 1'b0;
      c_pc         <= '0;
      w_regfile    <= 1'b0;
      sel_regfile  <= '0;
      data_regfile <= '0;
      misalign     <= 1'b0;
    end else if (accept) begin
      if (is_mem && !bad) begin
        p_pc     <= a_pc;
        p_addr   <= alu_result;
        p_rd     <= regD;
        p_size   <= mem_size;
        p_wen    <= w_en;
        p_ld     <= mem_rd;
        done     <= 1'b0;
        dm_we    <= mem_wr;
        dm_addr  <= {alu_result[XLEN-1:2], 2'b00};
        dm_wdata <= wdata;
        dm_be    <= be;
        c_valid  <= 1'b0;
      end else begin
        c_valid      <= 1'b1;
        c_pc         <= a_pc;
        sel_regfile  <= regD;
        data_regfile <= alu_result;
        w_regfile    <= !bad && w_en && (regD != '0);
        misalign     <= bad;
      end
    end else if (finish) begin
      done         <= 1'b0;
      c_valid      <= 1'b1;
      c_pc         <= p_pc;
      sel_regfile  <= p_rd;
      data_regfile <= p_ld ? ld_val : p_addr;
      w_regfile    <= p_ld && p_wen && (p_rd != '0);
      misalign     <= 1'b0;
    end else begin
      if (ack_hit) begin
        done <= 1'b1;
        rbuf <= dm_rdata;
      end
      if (w_ready) c_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c_stage.sv
// Bench for c_stage: directed steps, then random traffic against a
// byte-level memory model and an in-order expected-bundle queue.
module tb_c_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        c_ready;
  logic [31:0] a_pc = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  regD = '0;
  logic        w_en = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  mem_size = '0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        c_valid;
  logic        w_ready = 1'b1;
  logic [31:0] c_pc;
  logic        w_regfile;
  logic [4:0]  sel_regfile;
  logic [31:0] data_regfile;
  logic        misalign;

  always #5 clock = ~clock;

  c_stage dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .c_ready(c_ready),
    .a_pc(a_pc), .alu_result(alu_result),
    .store_data(store_data), .regD(regD),
    .w_en(w_en), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_size(mem_size),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .c_valid(c_valid),
    .w_ready(w_ready), .c_pc(c_pc),
    .w_regfile(w_regfile),
    .sel_regfile(sel_regfile),
    .data_regfile(data_regfile),
    .misalign(misalign)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        chk;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  mb[64];
  logic [31:0] rmem[16];
  logic        acc, hold, drain;
  logic [31:0] h_pc, h_data;
  logic [7:0]  h_ctl;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic put(input logic [31:0] pc, alu, sd, input logic [4:0] rd,
                     input logic we, ld, st, input logic [2:0] sz);
    a_valid = 1'b1; a_pc = pc; alu_result = alu; store_data = sd;
    regD = rd; w_en = we; mem_rd = ld; mem_wr = st; mem_size = sz;
  endtask

  task automatic mem_run(input string tag, input logic [31:0] alu, sd,
                         input logic ld, st, input logic [2:0] sz,
                         input logic [31:0] rdata, input int nreq,
                         input logic [31:0] x_addr, input logic [3:0] x_be,
                         input logic [31:0] x_wd, x_data, input logic x_w);
    nxt();
    put(32'h200, alu, sd, 5'd7, 1'b1, ld, st, sz);
    mid();
    chk({tag, "_accept"}, 32'(c_ready), 32'd1);
    for (int i = 1; i <= nreq; i++) begin
      nxt();
      a_valid = 1'b0;
      dm_ack = (i == nreq);
      dm_rdata = (i == nreq) ? rdata : 32'hDEADBEEF;
      mid();
      chk({tag, "_req"}, 32'(dm_req), 32'd1);
      chk({tag, "_nobundle"}, 32'(c_valid), 32'd0);
      chk({tag, "_addr"}, dm_addr, x_addr);
      chk({tag, "_we"}, 32'(dm_we), 32'(st));
      if (st) begin
        chk({tag, "_be"}, 32'(dm_be), 32'(x_be));
        chk({tag, "_wdata"}, dm_wdata, x_wd);
      end
    end
    nxt();
    dm_ack = 1'b0;
    mid();
    chk({tag, "_valid"}, 32'(c_valid), 32'd1);
    chk({tag, "_reqdrop"}, 32'(dm_req), 32'd0);
    chk({tag, "_wreg"}, 32'(w_regfile), 32'(x_w));
    chk({tag, "_mis"}, 32'(misalign), 32'd0);
    if (ld) chk({tag, "_data"}, data_regfile, x_data);
  endtask

  task automatic gen();
    int k;
    k = $urandom_range(0, 3);
    a_valid = 1'b1;
    a_pc = $urandom;
    store_data = $urandom;
    regD = 5'($urandom_range(0, 31));
    w_en = 1'($urandom_range(0, 1));
    mem_size = 3'($urandom_range(0, 7));
    mem_rd = (k == 2);
    mem_wr = (k == 3);
    alu_result = (k >= 2) ? 32'($urandom_range(0, 63)) : $urandom;
  endtask

  task automatic model_accept();
    exp_t x;
    int a, need;
    logic legal;
    logic [31:0] v;
    x.pc = a_pc; x.rd = regD; x.data = alu_result;
    x.we = w_en && (regD != 0); x.mis = 1'b0; x.chk = 1'b1;
    if (mem_rd || mem_wr) begin
      a = int'(alu_result[5:0]);
      legal = mem_size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      need = 1;
      if (mem_size == 3'd1 || mem_size == 3'd5) need = 2;
      if (mem_size == 3'd2) need = 4;
      if (!legal || (a % need) != 0) begin
        x.mis = 1'b1; x.we = 1'b0; x.chk = 1'b0;
      end else if (mem_wr) begin
        x.we = 1'b0; x.chk = 1'b0;
        for (int j = 0; j < need; j++) mb[a + j] = store_data[8*j +: 8];
      end else begin
        v = '0;
        for (int j = 0; j < need; j++) v = v | (32'(mb[a + j]) << (8 * j));
        if (mem_size == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (mem_size == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        x.data = v;
      end
    end
    sb.push_back(x);
  endtask

  initial begin
    // reset state
    nxt();
    nxt();
    mid();
    chk("rst_cvalid", 32'(c_valid), 32'd0);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_ready", 32'(c_ready), 32'd0);
    chk("rst_data", data_regfile, 32'd0);
    chk("rst_ctl", {28'd0, w_regfile, misalign, dm_we, c_valid}, 32'd0);

    // ADD, then rd=0 suppresses the write
    nxt();
    reset = 1'b0;
    put(32'h100, 32'h00001234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
    mid();
    chk("add_ready", 32'(c_ready), 32'd1);
    nxt();
    put(32'h104, 32'h00000055, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    mid();
    chk("add_valid", 32'(c_valid), 32'd1);
    chk("add_sel", 32'(sel_regfile), 32'd5);
    chk("add_data", data_regfile, 32'h00001234);
    chk("add_wreg", 32'(w_regfile), 32'd1);
    chk("add_pc", c_pc, 32'h100);
    chk("add_mis", 32'(misalign), 32'd0);
    nxt();
    a_valid = 1'b0;
    mid();
    chk("x0_valid", 32'(c_valid), 32'd1);
    chk("x0_wreg", 32'(w_regfile), 32'd0);

    // loads with 3 request cycles, halfword store
    mem_run("lb", 32'h103, 32'd0, 1'b1, 1'b0, 3'd0, 32'h80FFFFFF, 3,
            32'h100, 4'b0000, 32'd0, 32'hFFFFFF80, 1'b1);
    mem_run("lbu", 32'h103, 32'd0, 1'b1, 1'b0, 3'd4, 32'h80FFFFFF, 3,
            32'h100, 4'b0000, 32'd0, 32'h00000080, 1'b1);
    mem_run("lh", 32'h102, 32'd0, 1'b1, 1'b0, 3'd1, 32'h9ABC1234, 1,
            32'h100, 4'b0000, 32'd0, 32'hFFFF9ABC, 1'b1);
    mem_run("sh", 32'h102, 32'h0000ABCD, 1'b0, 1'b1, 3'd1, 32'd0, 2,
            32'h100, 4'b1100, 32'hABCDABCD, 32'd0, 1'b0);
    mem_run("sb", 32'h101, 32'h000000EF, 1'b0, 1'b1, 3'd0, 32'd0, 1,
            32'h100, 4'b0010, 32'hEFEFEFEF, 32'd0, 1'b0);

    // misaligned LW and illegal size
    nxt();
    put(32'h300, 32'h101, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2);
    nxt();
    put(32'h304, 32'h100, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd3);
    mid();
    chk("mis_req", 32'(dm_req), 32'd0);
    chk("mis_valid", 32'(c_valid), 32'd1);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_wreg", 32'(w_regfile), 32'd0);
    chk("mis_ready", 32'(c_ready), 32'd1);
    nxt();
    a_valid = 1'b0;
    mid();
    chk("ill_req", 32'(dm_req), 32'd0);
    chk("ill_flag", 32'(misalign), 32'd1);
    chk("ill_pc", c_pc, 32'h304);

    // W stall for 3 cycles, then back-to-back ADDs
    nxt();
    w_ready = 1'b0;
    put(32'h500, 32'hA1, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      put(32'h504, 32'hB2, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
      mid();
      chk("hold_valid", 32'(c_valid), 32'd1);
      chk("hold_ready", 32'(c_ready), 32'd0);
      chk("hold_data", data_regfile, 32'hA1);
      chk("hold_sel", 32'(sel_regfile), 32'd1);
    end
    nxt();
    w_ready = 1'b1;
    mid();
    chk("rel_ready", 32'(c_ready), 32'd1);
    nxt();
    put(32'h508, 32'hC3, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    mid();
    chk("b2b_b", data_regfile, 32'hB2);
    nxt();
    put(32'h50C, 32'hD4, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
    mid();
    chk("b2b_c", data_regfile, 32'hC3);
    chk("b2b_cv", 32'(c_valid), 32'd1);
    nxt();
    a_valid = 1'b0;
    mid();
    chk("b2b_d", data_regfile, 32'hD4);
    nxt();
    mid();
    chk("b2b_idle", 32'(c_valid), 32'd0);

    // reset in the 2nd cycle of a pending load; later ack ignored
    nxt();
    put(32'h600, 32'h40, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd2);
    nxt();
    a_valid = 1'b0;
    mid();
    chk("r6_req", 32'(dm_req), 32'd1);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 32'h12345678;
    mid();
    chk("r6_reqoff", 32'(dm_req), 32'd0);
    chk("r6_cvalid", 32'(c_valid), 32'd0);
    chk("r6_data", data_regfile, 32'd0);
    chk("r6_idle", 32'(c_ready), 32'd1);
    nxt();
    dm_ack = 1'b0;
    mid();
    chk("r6_noack", 32'(c_valid), 32'd0);
    nxt();
    mid();
    chk("r6_nobundle", 32'(c_valid), 32'd0);

    // random traffic
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)
      rmem[i] = {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    a_valid = 1'b0;
    acc = 1'b0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      drain = (cyc >= 3000);
      nxt();
      if (!a_valid || acc) begin
        if (!drain && $urandom_range(0, 9) < 8) gen();
        else a_valid = 1'b0;
      end
      if (drain) a_valid = 1'b0;
      w_ready = drain || ($urandom_range(0, 9) < 7);
      if (dm_req && $urandom_range(0, 9) < 4) begin
        dm_ack = 1'b1;
        dm_rdata = rmem[dm_addr[5:2]];
      end else begin
        dm_ack = 1'b0;
        dm_rdata = $urandom;
      end
      mid();
      if (hold) begin
        chk("rnd_hold_pc", c_pc, h_pc);
        chk("rnd_hold_data", data_regfile, h_data);
        chk("rnd_hold_ctl", 32'({sel_regfile, w_regfile, misalign, c_valid}),
            32'(h_ctl));
      end
      if (c_valid && w_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_extra_bundle", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("rnd_pc", c_pc, e.pc);
          chk("rnd_sel", 32'(sel_regfile), 32'(e.rd));
          chk("rnd_wreg", 32'(w_regfile), 32'(e.we));
          chk("rnd_mis", 32'(misalign), 32'(e.mis));
          if (e.chk) chk("rnd_data", data_regfile, e.data);
        end
      end
      hold = c_valid && !w_ready;
      h_pc = c_pc;
      h_data = data_regfile;
      h_ctl = {sel_regfile, w_regfile, misalign, c_valid};
      acc = a_valid && c_ready;
      if (acc) model_accept();
      if (dm_req && dm_ack && dm_we)
        for (int b = 0; b < 4; b++)
          if (dm_be[b]) rmem[dm_addr[5:2]][8*b +: 8] = dm_wdata[8*b +: 8];
    end
    chk("rnd_drained", 32'(sb.size()), 32'd0);
    chk("rnd_req_idle", 32'(dm_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
